// File: rtl/sdram_if_pkg.sv
// Shared types for the reader/writer/resp request interface.
// Used by the BRAM responder, the SDRAM driver and request initiators.
package sdram_if_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned SDRAM_DATA_W = 16;

  typedef logic [SDRAM_ADDR_W-1:0] addr_t;
  typedef logic [SDRAM_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FETCH,
    DRAIN
  } resp_state_e;

endpackage

// File: rtl/resp_skid_buf.sv
// Two-entry response FIFO: a registered output stage plus one skid entry.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_valid/i_data/i_last  word arriving from the RAM read register
//   o_space_c         1 when a read issued this cycle can be accepted
//                     two edges from now (accounts for the word in flight)
//   o_valid/o_data/o_last  registered response word
//   i_ready           consumer accepts o_* this cycle
module resp_skid_buf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_space_c,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_last;
  logic              w_pop;
  logic [1:0]        w_occ_nxt;

  assign w_pop = r_out_valid & i_ready;

  // Occupancy after the next edge; a new issue lands one edge later still.
  always_comb begin
    w_occ_nxt = {1'b0, r_out_valid} + {1'b0, r_skid_valid}
              + {1'b0, i_valid} - {1'b0, w_pop};
  end

  assign o_space_c = (w_occ_nxt <= 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_last   <= r_skid_last;
        r_skid_valid <= i_valid;
        if (i_valid) begin
          r_skid_data <= i_data;
          r_skid_last <= i_last;
        end
      end else begin
        r_out_valid <= i_valid;
        if (i_valid) begin
          r_out_data <= i_data;
          r_out_last <= i_last;
        end
      end
    end else if (!r_out_valid) begin
      r_out_valid <= i_valid;
      if (i_valid) begin
        r_out_data <= i_data;
        r_out_last <= i_last;
      end
    end else if (i_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
      r_skid_last  <= i_last;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
  assign o_last  = r_out_last;

endmodule

// File: rtl/sdram_bram_responder.sv
// Block-RAM backed responder for the reader/writer/resp request interface.
// Single-word writes; each read returns a BURST_LEN burst ending in resp_last,
// started READ_LATENCY idle cycles after acceptance.
// Ports:
//   clk_axi, rstn_axi                 clock, async active-low reset
//   reader_valid/ready/addr           read request (burst base address)
//   writer_valid/ready/addr/data      single-word write request
//   resp_valid/last/data, resp_ready  response stream
//   busy_o                            read burst in progress
//   rd_bursts_o, wr_words_o           wrapping activity counters
module sdram_bram_responder
  import sdram_if_pkg::*;
#(
  parameter int unsigned ADDR_W       = SDRAM_ADDR_W,
  parameter int unsigned DATA_W       = SDRAM_DATA_W,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk_axi,
  input  logic              rstn_axi,
  input  logic              reader_valid,
  output logic              reader_ready,
  input  logic [ADDR_W-1:0] reader_addr,
  input  logic              writer_valid,
  output logic              writer_ready,
  input  logic [ADDR_W-1:0] writer_addr,
  input  logic [DATA_W-1:0] writer_data,
  output logic              resp_valid,
  output logic              resp_last,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic              busy_o,
  output logic [15:0]       rd_bursts_o,
  output logic [15:0]       wr_words_o
);

  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WAIT_W = 4;

  resp_state_e       r_state;
  resp_state_e       w_state_nxt;
  logic              r_rdy;
  logic              r_busy;
  logic [15:0]       r_rd_bursts;
  logic [15:0]       r_wr_words;
  logic [MEM_AW-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_pend;
  logic              r_pend_last;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_issue;
  logic              w_space;
  logic              w_pop;
  logic              w_last_issue;
  logic              w_burst_done;
  logic [MEM_AW-1:0] w_rd_idx;
  logic              w_unused_addr;

  // Writes have fixed priority: a pending write masks read acceptance.
  assign writer_ready = r_rdy;
  assign reader_ready = r_rdy & ~writer_valid;
  assign busy_o       = r_busy;
  assign rd_bursts_o  = r_rd_bursts;
  assign wr_words_o   = r_wr_words;

  assign w_wr_fire    = writer_valid & r_rdy;
  assign w_rd_fire    = reader_valid & reader_ready;
  assign w_pop        = resp_valid & resp_ready;
  assign w_last_issue = (r_issue_cnt == CNT_W'(BURST_LEN - 1));
  assign w_burst_done = (r_state == DRAIN) & w_pop & resp_last;
  // Index arithmetic wraps naturally at the top of the RAM.
  assign w_rd_idx     = r_base + MEM_AW'(r_issue_cnt);
  // Upper address bits alias onto the RAM and are intentionally ignored.
  assign w_unused_addr = ^{reader_addr[ADDR_W-1:MEM_AW], writer_addr[ADDR_W-1:MEM_AW]};

  // State register
  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and read issue
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_fire) begin
          w_state_nxt = (READ_LATENCY != 0) ? WAIT : FETCH;
        end
      end
      WAIT: begin
        if (r_wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (w_space) begin
          w_issue = 1'b1;
          if (w_last_issue) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_burst_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping, registered status and counters
  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_bursts <= '0;
      r_wr_words  <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_wait_cnt  <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_rdy       <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_pend      <= w_issue;
      r_pend_last <= w_issue & w_last_issue;
      if (w_wr_fire) begin
        r_wr_words <= r_wr_words + 16'd1;
      end
      if (w_burst_done) begin
        r_rd_bursts <= r_rd_bursts + 16'd1;
      end
      if (w_rd_fire) begin
        r_base      <= reader_addr[MEM_AW-1:0];
        r_issue_cnt <= '0;
        r_wait_cnt  <= '0;
      end
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
    end
  end

  // Block RAM: contents survive reset; one-cycle registered read
  always_ff @(posedge clk_axi) begin
    if (w_wr_fire) begin
      r_mem[writer_addr[MEM_AW-1:0]] <= writer_data;
    end
    if (w_issue) begin
      r_ram_q <= r_mem[w_rd_idx];
    end
  end

  resp_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk_axi),
    .rst_n     (rstn_axi),
    .i_valid   (r_pend),
    .i_data    (r_ram_q),
    .i_last    (r_pend_last),
    .o_space_c (w_space),
    .o_valid   (resp_valid),
    .o_data    (resp_data),
    .o_last    (resp_last),
    .i_ready   (resp_ready)
  );

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Self-checking bench: random data and stalls against a memory-array model.
module tb_sdram_bram_responder;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int MAW   = 10;
  localparam int BL    = 8;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << MAW;

  logic          clk_axi = 1'b0;
  logic          rstn_axi = 1'b0;
  logic          reader_valid = 1'b0;
  logic          reader_ready;
  logic [AW-1:0] reader_addr = '0;
  logic          writer_valid = 1'b0;
  logic          writer_ready;
  logic [AW-1:0] writer_addr = '0;
  logic [DW-1:0] writer_data = '0;
  logic          resp_valid;
  logic          resp_last;
  logic [DW-1:0] resp_data;
  logic          resp_ready = 1'b0;
  logic          busy_o;
  logic [15:0]   rd_bursts_o;
  logic [15:0]   wr_words_o;

  sdram_bram_responder #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW), .BURST_LEN(BL), .READ_LATENCY(RL)
  ) dut (
    .clk_axi      (clk_axi),
    .rstn_axi     (rstn_axi),
    .reader_valid (reader_valid),
    .reader_ready (reader_ready),
    .reader_addr  (reader_addr),
    .writer_valid (writer_valid),
    .writer_ready (writer_ready),
    .writer_addr  (writer_addr),
    .writer_data  (writer_data),
    .resp_valid   (resp_valid),
    .resp_last    (resp_last),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .busy_o       (busy_o),
    .rd_bursts_o  (rd_bursts_o),
    .wr_words_o   (wr_words_o)
  );

  always #5 clk_axi = ~clk_axi;

  int cyc = 0;
  always @(posedge clk_axi) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [15:0]   exp_wr = '0;
  logic [15:0]   exp_rd = '0;

  // One write handshake; successive calls run back-to-back.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    @(negedge clk_axi);
    writer_valid = 1'b1;
    writer_addr  = a;
    writer_data  = d;
    #1;
    g = 0;
    while (writer_ready !== 1'b1 && g < 50) begin
      @(negedge clk_axi); #1; g++;
    end
    checks++;
    if (writer_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_timeout: writer_ready=%b required 1", writer_ready);
    end
    @(posedge clk_axi);
    model_mem[int'(a[MAW-1:0])] = d;
    exp_wr++;
  endtask

  task automatic write_done();
    @(negedge clk_axi);
    writer_valid = 1'b0;
  endtask

  // Returns the cycle index of the negedge following the accepting edge.
  task automatic issue_read(input logic [AW-1:0] base, output int t_idx);
    int g;
    @(negedge clk_axi);
    reader_valid = 1'b1;
    reader_addr  = base;
    #1;
    g = 0;
    while (reader_ready !== 1'b1 && g < 50) begin
      @(negedge clk_axi); #1; g++;
    end
    checks++;
    if (reader_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_ready_timeout: reader_ready=%b required 1", reader_ready);
    end
    @(posedge clk_axi);
    @(negedge clk_axi);
    reader_valid = 1'b0;
    t_idx = cyc;
  endtask

  // mode 0: resp_ready=1, 1: toggling, 2: random stalls
  task automatic collect_burst(input logic [AW-1:0] base, input int mode, input int t_idx,
                               input string name);
    int got, g, idx;
    bit held;
    logic rr, pl;
    logic [DW-1:0] pd, ed;
    checks++;
    if (busy_o !== 1'b1 || writer_ready !== 1'b0 || reader_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_state: busy=%b wr_rdy=%b rd_rdy=%b required 1 0 0",
               name, busy_o, writer_ready, reader_ready);
    end
    got = 0; g = 0; held = 0; pd = '0; pl = 1'b0;
    while (got < BL && g < 500) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (g % 2 == 0);
        default: rr = ($urandom_range(0, 2) != 0);
      endcase
      resp_ready = rr;
      #1;
      if (held) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== pd || resp_last !== pl) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b required 1 %h %b",
                   name, resp_valid, resp_data, resp_last, pd, pl);
        end
      end
      if (resp_valid === 1'b1) begin
        if (rr) begin
          idx = (int'(base[MAW-1:0]) + got) % DEPTH;
          ed  = model_mem[idx];
          checks++;
          if (resp_data !== ed || resp_last !== (got == BL - 1)) begin
            errors++;
            $display("FAIL %s word%0d: data=%h last=%b required %h %b",
                     name, got, resp_data, resp_last, ed, (got == BL - 1));
          end
          if (mode == 0) begin
            checks++;
            if (cyc != t_idx + RL + 2 + got) begin
              errors++;
              $display("FAIL %s timing word%0d: edge=T+%0d required T+%0d",
                       name, got, cyc - t_idx, RL + 2 + got);
            end
          end
          got++;
          held = 0;
        end else begin
          held = 1;
          pd = resp_data;
          pl = resp_last;
        end
      end
      @(negedge clk_axi);
      g++;
    end
    resp_ready = 1'b0;
    checks++;
    if (got != BL) begin
      errors++;
      $display("FAIL %s word_count: got=%0d required %0d", name, got, BL);
    end
    exp_rd++;
    checks++;
    if (resp_valid !== 1'b0 || busy_o !== 1'b0 || writer_ready !== 1'b1 ||
        rd_bursts_o !== exp_rd || wr_words_o !== exp_wr) begin
      errors++;
      $display("FAIL %s end_state: valid=%b busy=%b wr_rdy=%b bursts=%0d words=%0d required 0 0 1 %0d %0d",
               name, resp_valid, busy_o, writer_ready, rd_bursts_o, wr_words_o, exp_rd, exp_wr);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int mode, input string name);
    int t_idx;
    issue_read(base, t_idx);
    collect_burst(base, mode, t_idx, name);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (reader_ready !== 1'b0 || writer_ready !== 1'b0 || resp_valid !== 1'b0 ||
        resp_last !== 1'b0 || resp_data !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rd=%b wr=%b valid=%b last=%b data=%h busy=%b required all 0",
               reader_ready, writer_ready, resp_valid, resp_last, resp_data, busy_o);
    end
    @(negedge clk_axi);
    rstn_axi = 1'b1;
    @(negedge clk_axi);
    checks++;
    if (reader_ready !== 1'b1 || writer_ready !== 1'b1 || resp_valid !== 1'b0 ||
        rd_bursts_o !== 16'd0 || wr_words_o !== 16'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rd=%b wr=%b valid=%b bursts=%0d words=%0d busy=%b required 1 1 0 0 0 0",
               reader_ready, writer_ready, resp_valid, rd_bursts_o, wr_words_o, busy_o);
    end
  endtask

  task automatic test_write_read();
    int c0;
    @(negedge clk_axi);
    c0 = cyc;
    for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(16'h1234 + i));
    write_done();
    checks++;
    if (cyc != c0 + 9 || wr_words_o !== 16'd8) begin
      errors++;
      $display("FAIL b2b_writes: cycles=%0d words=%0d required 9 8", cyc - c0, wr_words_o);
    end
    run_burst(AW'(0), 0, "write_read");
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) do_write(AW'({$urandom_range(0, 255), 10'(i)}), DW'($urandom));
    write_done();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(16'h1234 + i));
    write_done();
    run_burst(AW'(0), 1, "toggle_stall");
    run_burst(AW'(0), 2, "random_stall");
  endtask

  task automatic test_priority();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int t_idx;
    a = AW'($urandom);
    d = DW'($urandom);
    @(negedge clk_axi);
    writer_valid = 1'b1; writer_addr = a; writer_data = d;
    reader_valid = 1'b1; reader_addr = a;
    #1;
    checks++;
    if (writer_ready !== 1'b1 || reader_ready !== 1'b0) begin
      errors++;
      $display("FAIL priority_mask: wr_rdy=%b rd_rdy=%b required 1 0", writer_ready, reader_ready);
    end
    @(posedge clk_axi);
    model_mem[int'(a[MAW-1:0])] = d;
    exp_wr++;
    @(negedge clk_axi);
    writer_valid = 1'b0;
    #1;
    checks++;
    if (reader_ready !== 1'b1) begin
      errors++;
      $display("FAIL priority_read_next: rd_rdy=%b required 1", reader_ready);
    end
    @(posedge clk_axi);
    @(negedge clk_axi);
    reader_valid = 1'b0;
    t_idx = cyc;
    collect_burst(a, 0, t_idx, "priority");
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wa;
    for (int i = 0; i < 8; i++) begin
      wa = AW'((16'h3FE + i) % DEPTH);
      do_write(wa, DW'(16'hA000 + i));
    end
    write_done();
    run_burst(AW'(24'h0003FE), 0, "wrap");
    run_burst(AW'(24'h0403FE), 2, "wrap_alias");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) do_write(AW'($urandom), DW'($urandom));
      write_done();
      run_burst(AW'($urandom), 2, "random");
    end
  endtask

  task automatic test_reset_midburst();
    logic [AW-1:0] base;
    int t_idx, got, g;
    base = AW'($urandom);
    issue_read(base, t_idx);
    resp_ready = 1'b1;
    got = 0; g = 0;
    while (got < 3 && g < 50) begin
      #1;
      if (resp_valid === 1'b1) got++;
      @(negedge clk_axi);
      g++;
    end
    checks++;
    if (got != 3 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: got=%0d valid=%b required 3 1", got, resp_valid);
    end
    rstn_axi = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_last !== 1'b0 || resp_data !== '0 || busy_o !== 1'b0 ||
        reader_ready !== 1'b0 || writer_ready !== 1'b0 || rd_bursts_o !== 16'd0 ||
        wr_words_o !== 16'd0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b last=%b data=%h busy=%b rd=%b wr=%b bursts=%0d words=%0d required all 0",
               resp_valid, resp_last, resp_data, busy_o, reader_ready, writer_ready,
               rd_bursts_o, wr_words_o);
    end
    resp_ready = 1'b0;
    @(negedge clk_axi);
    @(negedge clk_axi);
    rstn_axi = 1'b1;
    exp_wr = '0;
    exp_rd = '0;
    @(negedge clk_axi);
    run_burst(base, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    preload();
    test_stall();
    test_priority();
    test_wrap();
    test_random();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
